host_bus_decoder: RTL and testbench
===================================

# host_bus_decoder

Address decoder and response tracker between the VJTAG host bus master and the SDRAM controller user port. It routes each host request either to the SDRAM port or to a small local CSR bank, holds off new requests while a memory read is outstanding, and optionally aborts hung reads with a timeout. It gives the JTAG host a status and scratch area in addition to raw memory access.

## Interface
- AW, 16: address width; bit AW-1 selects the region (0 = SDRAM, 1 = CSR).
- DW, 16: data width.
- ID, 16'h5D01: value returned by CSR 0, truncated/zero-extended to DW.
- TIMEOUT, 255: read timeout in clk cycles, 1..2^16-1.
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- s_address  in  AW  host request address.
- s_wvalid  in  1  host write request.
- s_wdata  in  DW  host write data.
- s_wready  out  1  write accepted.
- s_rvalid  in  1  host read request.
- s_rready  out  1  read accepted.
- s_rrvalid  out  1  read response valid (1-cycle pulse).
- s_rdata  out  DW  read response data.
- m_address, m_wvalid, m_wdata, m_rvalid  out  AW/1/DW/1  SDRAM port request.
- m_wready, m_rready, m_rrvalid  in  1  SDRAM port handshakes.
- m_rdata  in  DW  SDRAM read data.

## Operation
- States: IDLE, MEM_RD, CSR_RSP. Reset → IDLE.
- IDLE, SDRAM region (s_address[AW-1]=0): combinational pass-through. m_wvalid=s_wvalid, m_rvalid=s_rvalid & ~s_wvalid, s_wready=m_wready, s_rready=m_rready & ~s_wvalid. m_address=s_address, m_wdata=s_wdata always.
- Accepted memory read (s_rvalid & s_rready) → MEM_RD. Accepted memory write stays in IDLE.
- MEM_RD: s_wready=s_rready=0, m_wvalid=m_rvalid=0. On m_rrvalid: s_rrvalid=1, s_rdata=m_rdata, → IDLE.
- IDLE, CSR region: s_wready=s_rready=1, m_* valids 0. A write updates the CSR on the next edge. A read captures CSR data into rsp_q, then → CSR_RSP.
- CSR_RSP: s_rrvalid=1, s_rdata=rsp_q, → IDLE. Requests are not accepted in this state.
- CSR map (s_address[3:0], upper CSR bits ignored):
  - 0 ID: read-only.
  - 1 SCRATCH: read/write.
  - 2 WR_CNT: accepted memory writes, wrapping.
  - 3 RD_CNT: accepted memory reads, wrapping.
  - 4 TO_CNT: timeouts, saturating at all-ones.
  - A write of any value to 2..4 clears that counter. Other offsets read 0; writes to them are ignored.
- Simultaneous counter increment and clear: clear wins.
- Simultaneous s_wvalid and s_rvalid: the write wins, and the read stays pending.
- m_rrvalid in IDLE or CSR_RSP (late response) is discarded and not forwarded.
- Outside the response cycle, s_rdata = rsp_q.

## Timing
- Reset values:
  - s_rrvalid=0, s_rdata=0, s_wready=s_rready=0. In IDLE the ready outputs follow the rules above from the first cycle after reset.
  - m_wvalid=m_rvalid=0.
  - SCRATCH=0, all counters=0, rsp_q=0.
- SDRAM path adds zero request latency and zero response latency (combinational).
- CSR write: visible to a read issued on the following cycle.
- CSR read: accepted at cycle N, s_rrvalid at N+1.
- Timeout counter is cleared on entry to MEM_RD and increments each cycle in MEM_RD. On the cycle it equals TIMEOUT-1 without m_rrvalid:
  - next cycle: s_rrvalid=1, s_rdata=DW'hDEAD;
  - TO_CNT increments; state → IDLE.
- m_rrvalid on the same cycle as expiry: real data is returned and no timeout is counted.
- Reset mid-operation forces IDLE and drops any pending response. No s_rrvalid is issued afterwards.

## Configuration
- HOST_BUS_TIMEOUT_EN:
  - Defined: timeout logic as above.
  - Undefined: no timeout counter. MEM_RD waits indefinitely for m_rrvalid. TO_CNT reads 0 and writes to it are ignored.

## Structure
- Package host_bus_pkg holds:
  - state enum (IDLE, MEM_RD, CSR_RSP);
  - CSR offset constants (CSR_ID=0 … CSR_TO_CNT=4);
  - timeout fill value 16'hDEAD.
- Sub-module host_bus_csr holds the CSR bank: write decode, counters, read mux. It takes increment strobes from the decoder FSM.

## Test plan
- Write 0x0012 ← 0xBEEF with m_wready=1 → m_wvalid/m_address/m_wdata passed in the same cycle; then read 0x8002 → WR_CNT=1.
- Read 0x0034; memory answers 0x1234 five cycles later → s_rrvalid one cycle with 0x1234. A write issued meanwhile sees s_wready=0 until the response.
- Write 0x8001 ← 0xA5A5, then read 0x8001 → s_rrvalid one cycle after accept, data 0xA5A5. Read 0x8000 → 0x5D01. Read 0x800F → 0x0000.
- With HOST_BUS_TIMEOUT_EN, TIMEOUT=8, memory never responds → s_rrvalid with 0xDEAD exactly 8 cycles after accept. TO_CNT=1. A late m_rrvalid is ignored.
- Write 0x8004 ← any while a timeout fires in the same cycle → TO_CNT reads 0.
- Assert rst_n=0 during MEM_RD → no s_rrvalid afterwards. SCRATCH and counters read 0.

Source files
------------

// File: rtl/host_bus_decoder_pkg.sv
// rtl/host_bus_decoder_pkg.sv - shared state encoding and CSR constants for host_bus_decoder
package host_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_RD  = 2'd1,
    CSR_RSP = 2'd2
  } state_e;

  localparam logic [3:0] CSR_ID      = 4'd0;
  localparam logic [3:0] CSR_SCRATCH = 4'd1;
  localparam logic [3:0] CSR_WR_CNT  = 4'd2;
  localparam logic [3:0] CSR_RD_CNT  = 4'd3;
  localparam logic [3:0] CSR_TO_CNT  = 4'd4;

  // Data returned to the host when a memory read is abandoned.
  localparam logic [15:0] TMO_FILL = 16'hDEAD;

endpackage

// File: rtl/host_bus_decoder_if.sv
// rtl/host_bus_decoder_if.sv - request/response bus used on both sides of the decoder
// Signals: address, wvalid, wdata, rvalid (master -> slave)
//          wready, rready, rrvalid, rdata (slave -> master)
interface host_bus_decoder_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [AW-1:0] address;
  logic          wvalid;
  logic [DW-1:0] wdata;
  logic          wready;
  logic          rvalid;
  logic          rready;
  logic          rrvalid;
  logic [DW-1:0] rdata;

  modport master (
    output address, wvalid, wdata, rvalid,
    input  wready, rready, rrvalid, rdata
  );

  modport slave (
    input  address, wvalid, wdata, rvalid,
    output wready, rready, rrvalid, rdata
  );
endinterface

// File: rtl/host_bus_decoder_csr.sv
// rtl/host_bus_decoder_csr.sv - local CSR bank: ID, scratch and access/timeout counters
// Ports: clk, rst_n (sync, active-low); we_i/addr_i/wdata_i write port;
//        wr_inc_i/rd_inc_i/to_inc_i counter strobes; rdata_o combinational read data.
// Macro: HOST_BUS_TIMEOUT_EN adds the TO_CNT register and its strobe input.
module host_bus_csr
  import host_bus_pkg::*;
#(
  parameter int          DW = 16,
  parameter logic [15:0] ID = 16'h5D01
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [3:0]    addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          wr_inc_i,
  input  logic          rd_inc_i,
`ifdef HOST_BUS_TIMEOUT_EN
  input  logic          to_inc_i,
`endif
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] scratch_q;
  logic [DW-1:0] wr_cnt_q;
  logic [DW-1:0] rd_cnt_q;
`ifdef HOST_BUS_TIMEOUT_EN
  logic [DW-1:0] to_cnt_q;
`endif

  // A write to a counter clears it and takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scratch_q <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
`ifdef HOST_BUS_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      if (we_i && addr_i == CSR_SCRATCH) scratch_q <= wdata_i;

      if (we_i && addr_i == CSR_WR_CNT) wr_cnt_q <= '0;
      else if (wr_inc_i)                wr_cnt_q <= wr_cnt_q + 1'b1;

      if (we_i && addr_i == CSR_RD_CNT) rd_cnt_q <= '0;
      else if (rd_inc_i)                rd_cnt_q <= rd_cnt_q + 1'b1;

`ifdef HOST_BUS_TIMEOUT_EN
      // Saturates so a long-running fault never looks healthy again.
      if (we_i && addr_i == CSR_TO_CNT)   to_cnt_q <= '0;
      else if (to_inc_i && to_cnt_q != '1) to_cnt_q <= to_cnt_q + 1'b1;
`endif
    end
  end

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      CSR_ID:      rdata_o = DW'(ID);
      CSR_SCRATCH: rdata_o = scratch_q;
      CSR_WR_CNT:  rdata_o = wr_cnt_q;
      CSR_RD_CNT:  rdata_o = rd_cnt_q;
`ifdef HOST_BUS_TIMEOUT_EN
      CSR_TO_CNT:  rdata_o = to_cnt_q;
`endif
      default:     rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/host_bus_decoder.sv
// rtl/host_bus_decoder.sv - routes host requests to the SDRAM port or the local CSR bank
// Ports: clk, rst_n (sync, active-low); s_if (slave, from VJTAG host master);
//        m_if (master, to SDRAM controller user port).
// Macro: HOST_BUS_TIMEOUT_EN enables abort of memory reads after TIMEOUT cycles.
module host_bus_decoder
  import host_bus_pkg::*;
#(
  parameter int          AW      = 16,
  parameter int          DW      = 16,
  parameter logic [15:0] ID      = 16'h5D01,
  parameter int          TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  host_bus_decoder_if.slave   s_if,
  host_bus_decoder_if.master  m_if
);

  localparam logic [DW-1:0] FILL = DW'(TMO_FILL);

  state_e        state_q, state_d;
  logic [DW-1:0] rsp_q, rsp_d;
  logic          csr_sel;
  logic          csr_we;
  logic [DW-1:0] csr_rdata;
  logic          wr_inc;
  logic          rd_inc;

  logic          s_wready, s_rready, s_rrvalid;
  logic [DW-1:0] s_rdata;
  logic          m_wvalid, m_rvalid;

`ifdef HOST_BUS_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  // tmo_q counts MEM_RD cycles including the current one, so the abort
  // response lands exactly TIMEOUT cycles after the read was accepted.
  logic [15:0] tmo_q, tmo_d;
  logic        tmo_fire_q, tmo_fire_d;
`endif

  assign csr_sel      = s_if.address[AW-1];
  assign m_if.address = s_if.address;
  assign m_if.wdata   = s_if.wdata;

  always_comb begin
    state_d   = state_q;
    rsp_d     = rsp_q;
    csr_we    = 1'b0;
    wr_inc    = 1'b0;
    rd_inc    = 1'b0;
    s_wready  = 1'b0;
    s_rready  = 1'b0;
    s_rrvalid = 1'b0;
    s_rdata   = rsp_q;
    m_wvalid  = 1'b0;
    m_rvalid  = 1'b0;
`ifdef HOST_BUS_TIMEOUT_EN
    tmo_d      = tmo_q;
    tmo_fire_d = 1'b0;
    // The abort response is issued from IDLE so new requests are not stalled.
    s_rrvalid  = tmo_fire_q;
`endif

    case (state_q)
      IDLE: begin
        if (!csr_sel) begin
          // Write wins a collision; the read is held off until the write is gone.
          m_wvalid = s_if.wvalid;
          m_rvalid = s_if.rvalid & ~s_if.wvalid;
          s_wready = m_if.wready;
          s_rready = m_if.rready & ~s_if.wvalid;
          wr_inc   = s_if.wvalid & m_if.wready;
          rd_inc   = s_if.rvalid & ~s_if.wvalid & m_if.rready;
          if (rd_inc) begin
            state_d = MEM_RD;
`ifdef HOST_BUS_TIMEOUT_EN
            tmo_d   = 16'd1;
`endif
          end
        end else begin
          s_wready = 1'b1;
          s_rready = ~s_if.wvalid;
          csr_we   = s_if.wvalid;
          if (s_if.rvalid && !s_if.wvalid) begin
            rsp_d   = csr_rdata;
            state_d = CSR_RSP;
          end
        end
      end

      MEM_RD: begin
        if (m_if.rrvalid) begin
          s_rrvalid = 1'b1;
          s_rdata   = m_if.rdata;
          state_d   = IDLE;
        end
`ifdef HOST_BUS_TIMEOUT_EN
        else if (tmo_q >= TMO_LAST) begin
          rsp_d      = FILL;
          tmo_fire_d = 1'b1;
          state_d    = IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end

      CSR_RSP: begin
        s_rrvalid = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Hold the host and memory handshakes quiet while reset is asserted.
    if (!rst_n) begin
      csr_we    = 1'b0;
      wr_inc    = 1'b0;
      rd_inc    = 1'b0;
      s_wready  = 1'b0;
      s_rready  = 1'b0;
      s_rrvalid = 1'b0;
      m_wvalid  = 1'b0;
      m_rvalid  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rsp_q      <= '0;
`ifdef HOST_BUS_TIMEOUT_EN
      tmo_q      <= '0;
      tmo_fire_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rsp_q      <= rsp_d;
`ifdef HOST_BUS_TIMEOUT_EN
      tmo_q      <= tmo_d;
      tmo_fire_q <= tmo_fire_d;
`endif
    end
  end

  assign s_if.wready  = s_wready;
  assign s_if.rready  = s_rready;
  assign s_if.rrvalid = s_rrvalid;
  assign s_if.rdata   = s_rdata;
  assign m_if.wvalid  = m_wvalid;
  assign m_if.rvalid  = m_rvalid;

  host_bus_csr #(
    .DW (DW),
    .ID (ID)
  ) u_csr (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (csr_we),
    .addr_i   (s_if.address[3:0]),
    .wdata_i  (s_if.wdata),
    .wr_inc_i (wr_inc),
    .rd_inc_i (rd_inc),
`ifdef HOST_BUS_TIMEOUT_EN
    .to_inc_i (tmo_fire_q),
`endif
    .rdata_o  (csr_rdata)
  );

endmodule

// File: tb/tb_host_bus_decoder.sv
// tb/tb_host_bus_decoder.sv - self-checking bench for host_bus_decoder
module tb_host_bus_decoder;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  // Reference model of the CSR bank state.
  logic [15:0] m_scratch, m_wr, m_rd, m_to;

  host_bus_decoder_if #(.AW(AW), .DW(DW)) s_bus ();
  host_bus_decoder_if #(.AW(AW), .DW(DW)) m_bus ();

  host_bus_decoder #(
    .AW(AW), .DW(DW), .ID(16'h5D01), .TIMEOUT(TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_if  (s_bus),
    .m_if  (m_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic quiet();
    s_bus.address = '0;
    s_bus.wvalid  = 1'b0;
    s_bus.wdata   = '0;
    s_bus.rvalid  = 1'b0;
    m_bus.wready  = 1'b0;
    m_bus.rready  = 1'b0;
    m_bus.rrvalid = 1'b0;
    m_bus.rdata   = '0;
  endtask

  function automatic logic [15:0] csr_model(input logic [3:0] off);
    case (off)
      4'd0: return 16'h5D01;
      4'd1: return m_scratch;
      4'd2: return m_wr;
      4'd3: return m_rd;
`ifdef HOST_BUS_TIMEOUT_EN
      4'd4: return m_to;
`endif
      default: return 16'h0000;
    endcase
  endfunction

  task automatic csr_write(input logic [15:0] addr, input logic [15:0] d);
    s_bus.address = addr;
    s_bus.wdata   = d;
    s_bus.wvalid  = 1'b1;
    sample();
    check("csr_wready", s_bus.wready, 1'b1);
    step();
    quiet();
    case (addr[3:0])
      4'd1: m_scratch = d;
      4'd2: m_wr = '0;
      4'd3: m_rd = '0;
      4'd4: m_to = '0;
      default: ;
    endcase
  endtask

  task automatic csr_read(input logic [15:0] addr, input string tag);
    logic [15:0] exp;
    exp = csr_model(addr[3:0]);
    s_bus.address = addr;
    s_bus.rvalid  = 1'b1;
    sample();
    check("csr_rready", s_bus.rready, 1'b1);
    check("csr_no_early_rsp", s_bus.rrvalid, 1'b0);
    step();
    quiet();
    sample();
    check({tag, "_rrvalid"}, s_bus.rrvalid, 1'b1);
    check(tag, s_bus.rdata, exp);
    step();
  endtask

  task automatic mem_write(input logic [15:0] addr, input logic [15:0] d);
    m_bus.wready  = 1'b1;
    s_bus.address = addr;
    s_bus.wdata   = d;
    s_bus.wvalid  = 1'b1;
    sample();
    check("mw_m_wvalid", m_bus.wvalid, 1'b1);
    check("mw_m_address", m_bus.address, addr);
    check("mw_m_wdata", m_bus.wdata, d);
    check("mw_s_wready", s_bus.wready, 1'b1);
    step();
    quiet();
    m_wr = m_wr + 16'd1;
  endtask

  task automatic mem_read(input logic [15:0] addr, input logic [15:0] d, input int lat, input bit probe);
    bit busy_ok;
    m_bus.rready  = 1'b1;
    s_bus.address = addr;
    s_bus.rvalid  = 1'b1;
    sample();
    check("mr_m_rvalid", m_bus.rvalid, 1'b1);
    check("mr_m_address", m_bus.address, addr);
    check("mr_s_rready", s_bus.rready, 1'b1);
    step();
    quiet();
    m_rd = m_rd + 16'd1;
    if (probe) begin
      s_bus.address = {1'b0, 15'($urandom)};
      s_bus.wvalid  = 1'b1;
      m_bus.wready  = 1'b1;
    end
    busy_ok = 1'b1;
    for (int i = 1; i < lat; i++) begin
      sample();
      if (s_bus.wready || s_bus.rready || m_bus.wvalid || m_bus.rvalid || s_bus.rrvalid) busy_ok = 1'b0;
      step();
    end
    check("mr_busy_quiet", busy_ok, 1'b1);
    m_bus.rrvalid = 1'b1;
    m_bus.rdata   = d;
    sample();
    check("mr_rrvalid", s_bus.rrvalid, 1'b1);
    check("mr_rdata", s_bus.rdata, d);
    if (probe) check("mr_wready_held", s_bus.wready, 1'b0);
    step();
    quiet();
    sample();
    check("mr_rrvalid_pulse", s_bus.rrvalid, 1'b0);
    step();
  endtask

  initial begin
    int cyc;
    int seen;
    logic [3:0] off;
    logic [15:0] a, d;

    quiet();
    m_scratch = '0; m_wr = '0; m_rd = '0; m_to = '0;

    // Reset with live requests: nothing may be accepted or forwarded.
    rst_n = 1'b0;
    s_bus.address = 16'h0012; s_bus.wvalid = 1'b1; s_bus.wdata = 16'hFFFF;
    m_bus.wready = 1'b1; m_bus.rready = 1'b1;
    step();
    sample();
    check("rst_m_wvalid", m_bus.wvalid, 1'b0);
    check("rst_s_wready", s_bus.wready, 1'b0);
    step();
    s_bus.address = 16'h8001;
    s_bus.rvalid  = 1'b1;
    sample();
    check("rst_csr_wready", s_bus.wready, 1'b0);
    check("rst_s_rready", s_bus.rready, 1'b0);
    check("rst_m_rvalid", m_bus.rvalid, 1'b0);
    step();
    quiet();
    rst_n = 1'b1;
    m_bus.wready = 1'b1;
    sample();
    check("post_rst_rrvalid", s_bus.rrvalid, 1'b0);
    check("post_rst_rdata", s_bus.rdata, 16'h0000);
    check("post_rst_wready_follows", s_bus.wready, 1'b1);
    step();
    quiet();
    csr_read(16'h8001, "scratch_after_rst");

    // Directed plan.
    mem_write(16'h0012, 16'hBEEF);
    csr_read(16'h8002, "wr_cnt_1");
    mem_read(16'h0034, 16'h1234, 5, 1'b1);
    csr_write(16'h8001, 16'hA5A5);
    csr_read(16'h8001, "scratch_a5a5");
    csr_read(16'h8000, "id");
    csr_read(16'h800F, "unmapped_f");
    csr_write(16'h8000, 16'h1111);
    csr_read(16'h8000, "id_readonly");

    // Write and read together: write goes first, the read follows once it drops.
    s_bus.address = 16'h0056; s_bus.wdata = 16'h7777;
    s_bus.wvalid = 1'b1; s_bus.rvalid = 1'b1;
    m_bus.wready = 1'b1; m_bus.rready = 1'b1;
    sample();
    check("coll_m_wvalid", m_bus.wvalid, 1'b1);
    check("coll_m_rvalid", m_bus.rvalid, 1'b0);
    check("coll_s_rready", s_bus.rready, 1'b0);
    step();
    m_wr = m_wr + 16'd1;
    s_bus.wvalid = 1'b0;
    sample();
    check("pend_m_rvalid", m_bus.rvalid, 1'b1);
    check("pend_s_rready", s_bus.rready, 1'b1);
    step();
    quiet();
    m_rd = m_rd + 16'd1;
    m_bus.rrvalid = 1'b1; m_bus.rdata = 16'h4321;
    sample();
    check("pend_rdata", s_bus.rdata, 16'h4321);
    check("pend_rrvalid", s_bus.rrvalid, 1'b1);
    step();
    quiet();

    // Unsolicited memory response in IDLE is dropped.
    m_bus.rrvalid = 1'b1; m_bus.rdata = 16'h9999;
    sample();
    check("stray_rsp_idle", s_bus.rrvalid, 1'b0);
    step();
    quiet();

    // Randomized mix checked against the model.
    for (int it = 0; it < 16; it++) begin
      d = 16'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          a = {1'b1, 11'($urandom), 4'd1};
          csr_write(a, d);
          csr_read({1'b1, 11'($urandom), 4'd1}, "rnd_scratch");
        end
        1: mem_write({1'b0, 15'($urandom)}, d);
        2: mem_read({1'b0, 15'($urandom)}, d, $urandom_range(1, 6), 1'($urandom));
        default: begin
          off = 4'($urandom_range(5, 15));
          csr_write({1'b1, 11'($urandom), off}, d);
          csr_read({1'b1, 11'($urandom), off}, "rnd_unmapped");
          csr_read(16'h8001, "rnd_scratch_kept");
        end
      endcase
    end
    csr_read(16'h8002, "rnd_wr_cnt");
    csr_read(16'h8003, "rnd_rd_cnt");
    csr_write(16'h8002, 16'($urandom));
    csr_read(16'h8002, "wr_cnt_cleared");

`ifdef HOST_BUS_TIMEOUT_EN
    // Memory never answers: abort response exactly TMO cycles after accept.
    m_bus.rready = 1'b1; s_bus.address = 16'h0040; s_bus.rvalid = 1'b1;
    step();
    quiet();
    m_rd = m_rd + 16'd1;
    cyc = 1;
    while (cyc < 4 * TMO) begin
      sample();
      if (s_bus.rrvalid) break;
      step();
      cyc++;
    end
    check("tmo_latency", cyc, TMO);
    check("tmo_fill", s_bus.rdata, 16'hDEAD);
    step();
    m_to = m_to + 16'd1;
    m_bus.rrvalid = 1'b1; m_bus.rdata = 16'h5555;
    sample();
    check("tmo_late_rsp", s_bus.rrvalid, 1'b0);
    step();
    quiet();
    csr_read(16'h8004, "to_cnt_1");

    // Clear of TO_CNT coinciding with the increment: clear wins.
    m_bus.rready = 1'b1; s_bus.address = 16'h0044; s_bus.rvalid = 1'b1;
    step();
    quiet();
    m_rd = m_rd + 16'd1;
    repeat (TMO - 1) step();
    s_bus.address = 16'h8004; s_bus.wdata = 16'($urandom); s_bus.wvalid = 1'b1;
    sample();
    check("tmo2_rrvalid", s_bus.rrvalid, 1'b1);
    check("tmo2_wready", s_bus.wready, 1'b1);
    step();
    quiet();
    m_to = '0;
    csr_read(16'h8004, "to_cnt_clear_wins");
    csr_read(16'h8003, "rd_cnt_after_tmo");

    // Enter MEM_RD for the reset test.
    m_bus.rready = 1'b1; s_bus.address = 16'h0050; s_bus.rvalid = 1'b1;
    step();
    quiet();
    step();
`else
    // Without the timeout the read waits indefinitely.
    m_bus.rready = 1'b1; s_bus.address = 16'h0040; s_bus.rvalid = 1'b1;
    step();
    quiet();
    seen = 0;
    repeat (40) begin
      sample();
      if (s_bus.rrvalid) seen++;
      step();
    end
    check("no_tmo_wait", seen, 0);
`endif

    // Reset in MEM_RD: the outstanding response is dropped.
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    m_scratch = '0; m_wr = '0; m_rd = '0; m_to = '0;
    m_bus.rrvalid = 1'b1; m_bus.rdata = 16'hCAFE;
    seen = 0;
    repeat (12) begin
      sample();
      if (s_bus.rrvalid) seen++;
      step();
      m_bus.rrvalid = 1'b0;
    end
    check("rst_drop_rsp", seen, 0);
    csr_read(16'h8001, "rst_scratch");
    csr_read(16'h8002, "rst_wr_cnt");
    csr_read(16'h8003, "rst_rd_cnt");
    csr_write(16'h8004, 16'h00FF);
    csr_read(16'h8004, "rst_to_cnt");
    csr_read(16'h8000, "rst_id");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
